spi_vram_writer: RTL
====================

SPI_VRAM_WRITER -- requirements
Module: spi_vram_writer

Interface
REQ-001 Parameter AWIDTH, default 19: width of the video memory address.
REQ-002 Parameter DWIDTH, default 8: width of the memory data byte.
REQ-003 MemClk  input  1  memory-domain clock; the only clock of the block.
REQ-004 RstN  input  1  reset, asynchronous and active-low.
REQ-005 Sclk  input  1  SPI serial clock from the host, asynchronous to MemClk.
REQ-006 Mosi  input  1  SPI data from the host, MSB first.
REQ-007 Csel  input  1  SPI chip select, active-low; each low period is one frame.
REQ-008 WriteReq  output  1  write request to the vmmu write port.
REQ-009 WriteAddr  output  AWIDTH  address of the pending write.
REQ-010 WriteData  output  DWIDTH  data of the pending write.
REQ-011 WriteAck  input  1  one-cycle pulse from the vmmu: pending write accepted.
REQ-012 Busy  output  1  high while a frame is active (synchronized Csel low).
REQ-013 Overrun  output  1  sticky flag: a data byte was dropped.

Function
REQ-014 The block SHALL pass Sclk, Mosi and Csel through two-flop synchronizers on MemClk.
REQ-015 The block SHALL detect Sclk rising edges on the synchronized signal and sample synchronized Mosi on each detected edge (SPI mode 0).
REQ-016 Sclk frequency SHALL be at most MemClk/4; behaviour above this limit is undefined.
REQ-017 A 3-bit bit counter SHALL assemble bytes MSB first and wrap 7->0 on byte completion.
REQ-018 FSM states: IDLE, CMD, ADDR, DATA, SKIP.
- IDLE->CMD on synchronized Csel falling.
REQ-019 CMD transitions on its completed byte:
- 0x02 -> ADDR, with the address byte counter cleared.
- any other value -> SKIP.
REQ-020 ADDR SHALL take 3 bytes MSB first; the low AWIDTH bits form the start address and the upper bits are ignored; DATA follows after byte 3.
REQ-021 In DATA, each completed byte SHALL be loaded into WriteData with the current address into WriteAddr, and the address SHALL then increment.
REQ-022 The address SHALL wrap from 2^AWIDTH-1 to 0.
REQ-023 SKIP SHALL ignore all bits until Csel rises.
REQ-024 Synchronized Csel rising in any state SHALL return the FSM to IDLE and discard a partial byte and the bit count.
REQ-025 WriteReq SHALL assert on the MemClk cycle after byte completion.
REQ-026 WriteReq, WriteAddr and WriteData SHALL then hold stable until the cycle WriteAck is sampled high; WriteReq deasserts the following cycle.
REQ-027 WriteAck while WriteReq is low SHALL be ignored.
REQ-028 A pending write SHALL complete even if the frame ends before WriteAck.
REQ-029 Overrun:
- a DATA byte completing while WriteReq is high and WriteAck is low SHALL be dropped;
- the address SHALL still increment;
- Overrun SHALL set.
REQ-030 A byte completing in the same cycle as WriteAck SHALL be accepted, with no overrun.
REQ-031 Overrun SHALL clear only on a new frame start (IDLE->CMD) or on reset.
REQ-032 Busy SHALL equal the inverse of synchronized Csel.

Reset
REQ-033 While RstN is low: FSM=IDLE; counters, WriteReq, WriteAddr, WriteData, Busy and Overrun SHALL be 0; synchronizers SHALL preset to Csel=1 and Sclk=0.
REQ-034 Reset asserted mid-write SHALL drop the pending request without waiting for WriteAck.

Structure
REQ-035 The FSM state encodings, command code 0x02 and address byte count 3 SHALL reside in a shared vga_pkg definitions file, alongside the vmmu constants.
REQ-036 The synchronizer plus edge detector SHALL be one sub-module, spi_sync, instantiated once for all three inputs.

Verification
REQ-037 Frame 02 00 00 10 AA BB with WriteAck returned 2 cycles after each WriteReq -> writes (0x00010,0xAA) then (0x00011,0xBB); Overrun=0.
REQ-038 Frame 02 07 FF FF 11 22 -> writes (0x7FFFF,0x11) then (0x00000,0x22); the wrap is correct.
REQ-039 Frame 03 00 00 00 55 -> no WriteReq; FSM=SKIP until Csel high, then IDLE.
REQ-040 Frame 02 00 00 00 then 3 bytes with WriteAck held low -> exactly one WriteReq at 0x00000 held stable; Overrun=1; the next frame start clears it.
REQ-041 Csel raised after 5 bits of the 2nd address byte, then frame 02 00 00 01 C3 -> single write (0x00001,0xC3).
REQ-042 RstN pulsed low while WriteReq is high -> all outputs 0 immediately; a subsequent WriteAck is ignored.

Source files
------------

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared video-path definitions: vmmu constants and SPI writer FSM/command codes
package vga_pkg;

  // vmmu write port geometry
  localparam int VMMU_AWIDTH = 19;
  localparam int VMMU_DWIDTH = 8;

  // SPI writer protocol constants
  localparam logic [7:0] SPI_CMD_WRITE  = 8'h02;
  localparam logic [1:0] SPI_ADDR_BYTES = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_ADDR = 3'd2,
    ST_DATA = 3'd3,
    ST_SKIP = 3'd4
  } spi_wr_state_e;

endpackage

// File: rtl/spi_vram_writer_if.sv
// rtl/spi_vram_writer_if.sv - vmmu write-port handshake between the SPI writer and the memory unit
interface spi_vram_writer_if
  import vga_pkg::*;
#(
  parameter int AWIDTH = VMMU_AWIDTH,
  parameter int DWIDTH = VMMU_DWIDTH
);
  logic              WriteReq;
  logic [AWIDTH-1:0] WriteAddr;
  logic [DWIDTH-1:0] WriteData;
  logic              WriteAck;

  modport master (output WriteReq, output WriteAddr, output WriteData, input WriteAck);
  modport slave  (input WriteReq, input WriteAddr, input WriteData, output WriteAck);
endinterface

// File: rtl/spi_sync.sv
// rtl/spi_sync.sv - two-flop synchronizers and edge detectors for the SPI pins
module spi_sync (
  input  logic MemClk,
  input  logic RstN,
  input  logic sclk_i,
  input  logic mosi_i,
  input  logic csel_i,
  output logic sclk_rise_o,
  output logic mosi_o,
  output logic csel_o,
  output logic csel_fall_o,
  output logic csel_rise_o
);
  // [0],[1] are the synchronizer pair; [2] holds the previous synchronized value for edges
  logic [2:0] sclk_q;
  logic [2:0] csel_q;
  logic [1:0] mosi_q;

  // shift raw pins into the MemClk domain; idle bus is Csel high, Sclk low
  always_ff @(posedge MemClk or negedge RstN) begin
    if (!RstN) begin
      sclk_q <= 3'b000;
      csel_q <= 3'b111;
      mosi_q <= 2'b00;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk_i};
      csel_q <= {csel_q[1:0], csel_i};
      mosi_q <= {mosi_q[0], mosi_i};
    end
  end

  assign mosi_o      = mosi_q[1];
  assign csel_o      = csel_q[1];
  assign sclk_rise_o = sclk_q[1] & ~sclk_q[2];
  assign csel_fall_o = ~csel_q[1] & csel_q[2];
  assign csel_rise_o = csel_q[1] & ~csel_q[2];
endmodule

// File: rtl/spi_vram_writer.sv
// rtl/spi_vram_writer.sv - SPI slave that turns write frames into vmmu write requests
module spi_vram_writer
  import vga_pkg::*;
#(
  parameter int AWIDTH = VMMU_AWIDTH,
  parameter int DWIDTH = VMMU_DWIDTH
) (
  input  logic                     MemClk,
  input  logic                     RstN,
  input  logic                     Sclk,
  input  logic                     Mosi,
  input  logic                     Csel,
  spi_vram_writer_if.master        wr,
  output logic                     Busy,
  output logic                     Overrun
);
  localparam logic [1:0] ADDR_LAST = SPI_ADDR_BYTES - 2'd1;

  logic sclk_rise, mosi_s, csel_s, csel_fall, csel_rise;

  spi_sync u_sync (
    .MemClk      (MemClk),
    .RstN        (RstN),
    .sclk_i      (Sclk),
    .mosi_i      (Mosi),
    .csel_i      (Csel),
    .sclk_rise_o (sclk_rise),
    .mosi_o      (mosi_s),
    .csel_o      (csel_s),
    .csel_fall_o (csel_fall),
    .csel_rise_o (csel_rise)
  );

  spi_wr_state_e     state_q;
  logic [2:0]        bit_cnt_q;
  logic [6:0]        shift_q;
  logic [1:0]        abyte_q;
  logic [15:0]       addr_acc_q;
  logic [AWIDTH-1:0] addr_q;
  logic              req_q;
  logic [AWIDTH-1:0] waddr_q;
  logic [DWIDTH-1:0] wdata_q;
  logic              ovr_q;

  // byte as it stands once the current bit is shifted in
  logic [7:0] byte_d;
  assign byte_d = {shift_q, mosi_s};

  // frame FSM, byte assembly, address tracking and the write handshake
  always_ff @(posedge MemClk or negedge RstN) begin
    if (!RstN) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 7'd0;
      abyte_q    <= 2'd0;
      addr_acc_q <= 16'd0;
      addr_q     <= '0;
      req_q      <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      ovr_q      <= 1'b0;
    end else begin
      // the pending write retires on ack regardless of frame state
      if (req_q && wr.WriteAck) req_q <= 1'b0;

      if (csel_rise) begin
        state_q   <= ST_IDLE;
        bit_cnt_q <= 3'd0;
        shift_q   <= 7'd0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (csel_fall) begin
              state_q   <= ST_CMD;
              bit_cnt_q <= 3'd0;
              shift_q   <= 7'd0;
              ovr_q     <= 1'b0;
            end
          end
          ST_CMD, ST_ADDR, ST_DATA: begin
            if (sclk_rise) begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              shift_q   <= byte_d[6:0];
              if (bit_cnt_q == 3'd7) begin
                case (state_q)
                  ST_CMD: begin
                    if (byte_d == SPI_CMD_WRITE) begin
                      state_q <= ST_ADDR;
                      abyte_q <= 2'd0;
                    end else begin
                      state_q <= ST_SKIP;
                    end
                  end
                  ST_ADDR: begin
                    addr_acc_q <= {addr_acc_q[7:0], byte_d};
                    abyte_q    <= abyte_q + 2'd1;
                    if (abyte_q == ADDR_LAST) begin
                      addr_q  <= AWIDTH'({addr_acc_q, byte_d});
                      state_q <= ST_DATA;
                    end
                  end
                  default: begin
                    // a byte landing on the ack cycle takes the freed slot
                    if (!req_q || wr.WriteAck) begin
                      req_q   <= 1'b1;
                      waddr_q <= addr_q;
                      wdata_q <= DWIDTH'(byte_d);
                    end else begin
                      ovr_q <= 1'b1;
                    end
                    addr_q <= addr_q + AWIDTH'(1);
                  end
                endcase
              end
            end
          end
          ST_SKIP: ;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign wr.WriteReq  = req_q;
  assign wr.WriteAddr = waddr_q;
  assign wr.WriteData = wdata_q;
  assign Busy         = ~csel_s;
  assign Overrun      = ovr_q;
endmodule
